// File: rtl/register_file_param.sv
// Parametrised register file: 1 write port, 2 async read ports, pending scoreboard, bulk-clear engine.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module register_file_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr1,
    input  logic [AW-1:0]     rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_ready1,
    output logic              rd_ready2,
    input  logic              pend_set,
    input  logic [AW-1:0]     pend_addr,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t              state;
    logic [AW-1:0]       cnt;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    pending;

    logic wr_in, pend_in, rd1_in, rd2_in;
    logic wr_ok, pend_ok;

    assign wr_in   = {1'b0, wr_addr}   < DEPTH_W;
    assign pend_in = {1'b0, pend_addr} < DEPTH_W;
    assign rd1_in  = {1'b0, rd_addr1}  < DEPTH_W;
    assign rd2_in  = {1'b0, rd_addr2}  < DEPTH_W;

    // Register 0 is never stored to when hardwired, so it keeps its reset value of zero.
    assign wr_ok   = wr_en && !clr_busy && wr_in && !(ZERO_REG && (wr_addr == '0));
    assign pend_ok = pend_set && !clr_busy && pend_in && !(ZERO_REG && (pend_addr == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            pending  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_ok) begin
                        regs[wr_addr]    <= wr_data;
                        pending[wr_addr] <= 1'b0;
                    end
                    // A result newly in flight outranks a same-cycle writeback.
                    if (pend_ok) begin
                        pending[pend_addr] <= 1'b1;
                    end
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        clr_busy <= 1'b1;
                        cnt      <= '0;
                    end
                end
                ST_CLEAR: begin
                    regs[cnt]    <= '0;
                    pending[cnt] <= 1'b0;
                    if (cnt == LAST) begin
                        state    <= ST_IDLE;
                        clr_busy <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    clr_busy <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data1  = '0;
        rd_ready1 = 1'b1;
        rd_data2  = '0;
        rd_ready2 = 1'b1;
        if (rd1_in) begin
            rd_data1  = regs[rd_addr1];
            rd_ready1 = ~pending[rd_addr1];
        end
        if (rd2_in) begin
            rd_data2  = regs[rd_addr2];
            rd_ready2 = ~pending[rd_addr2];
        end
`ifdef RF_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr1)) begin
            rd_data1  = wr_data;
            rd_ready1 = 1'b1;
        end
        if (wr_ok && (wr_addr == rd_addr2)) begin
            rd_data2  = wr_data;
            rd_ready2 = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: a default 4-entry instance and a 5-entry hardwired-zero instance,
// checked every cycle against an array-based reference model.
module tb_register_file_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en, pend_set, clr_req;
    logic [2:0] wr_addr, rd_addr1, rd_addr2, pend_addr;
    logic [7:0] wr_data;

    logic [7:0] a_d1, a_d2, b_d1, b_d2;
    logic       a_r1, a_r2, b_r1, b_r2, a_busy, b_busy;

    always #5 clk = ~clk;

    register_file_param dut_a (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
        .rd_addr1(rd_addr1[1:0]), .rd_addr2(rd_addr2[1:0]),
        .rd_data1(a_d1), .rd_data2(a_d2), .rd_ready1(a_r1), .rd_ready2(a_r2),
        .pend_set(pend_set), .pend_addr(pend_addr[1:0]),
        .clr_req(clr_req), .clr_busy(a_busy)
    );

    register_file_param #(.DATA_W(8), .DEPTH(5), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b_d1), .rd_data2(b_d2), .rd_ready1(b_r1), .rd_ready2(b_r2),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .clr_req(clr_req), .clr_busy(b_busy)
    );

    // Reference model: per-instance storage and the number of clear cycles still to run.
    int         dep [2] = '{4, 5};
    int         msk [2] = '{3, 7};
    bit         zr  [2] = '{1'b0, 1'b1};
    logic [7:0] m_reg  [2][8];
    bit         m_pend [2][8];
    int         m_left [2];

    int tests = 0;
    int fails = 0;

    function automatic bit wr_acc(int i);
        int a = int'(wr_addr) & msk[i];
        return wr_en && (m_left[i] == 0) && (a < dep[i]) && !(zr[i] && a == 0);
    endfunction

    function automatic logic [7:0] exp_data(int i, logic [2:0] ra);
        int a = int'(ra) & msk[i];
`ifdef RF_BYPASS_EN
        if (wr_acc(i) && a == (int'(wr_addr) & msk[i])) return wr_data;
`endif
        if (a >= dep[i]) return 8'h00;
        return m_reg[i][a];
    endfunction

    function automatic logic [7:0] exp_rdy(int i, logic [2:0] ra);
        int a = int'(ra) & msk[i];
`ifdef RF_BYPASS_EN
        if (wr_acc(i) && a == (int'(wr_addr) & msk[i])) return 8'h01;
`endif
        if (a >= dep[i]) return 8'h01;
        return m_pend[i][a] ? 8'h00 : 8'h01;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0;
            for (int k = 0; k < 8; k++) begin
                m_reg[i][k]  = 8'h00;
                m_pend[i][k] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int wa = int'(wr_addr) & msk[i];
            int pa = int'(pend_addr) & msk[i];
            if (m_left[i] > 0) begin
                int k = dep[i] - m_left[i];
                m_reg[i][k]  = 8'h00;
                m_pend[i][k] = 1'b0;
                m_left[i]--;
            end else begin
                if (wr_acc(i)) begin
                    m_reg[i][wa]  = wr_data;
                    m_pend[i][wa] = 1'b0;
                end
                if (pend_set && pa < dep[i] && !(zr[i] && pa == 0)) m_pend[i][pa] = 1'b1;
                if (clr_req) m_left[i] = dep[i];
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 2; i++) begin
            logic [7:0] g1 = (i == 0) ? a_d1 : b_d1;
            logic [7:0] g2 = (i == 0) ? a_d2 : b_d2;
            logic       y1 = (i == 0) ? a_r1 : b_r1;
            logic       y2 = (i == 0) ? a_r2 : b_r2;
            logic       bz = (i == 0) ? a_busy : b_busy;
            chk($sformatf("%s/i%0d/rd_data1", tag, i), g1, exp_data(i, rd_addr1));
            chk($sformatf("%s/i%0d/rd_data2", tag, i), g2, exp_data(i, rd_addr2));
            chk($sformatf("%s/i%0d/rd_ready1", tag, i), {7'd0, y1}, exp_rdy(i, rd_addr1));
            chk($sformatf("%s/i%0d/rd_ready2", tag, i), {7'd0, y2}, exp_rdy(i, rd_addr2));
            chk($sformatf("%s/i%0d/clr_busy", tag, i), {7'd0, bz}, {7'd0, m_left[i] != 0});
        end
    endtask

    task automatic step(input bit we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic [2:0] r1, input logic [2:0] r2,
                        input bit ps, input logic [2:0] pa, input bit cr, input string tag);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr1 = r1; rd_addr2 = r2;
        pend_set = ps; pend_addr = pa; clr_req = cr;
        #1 check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
        pend_set = 1'b0; pend_addr = '0; clr_req = 1'b0;
        model_reset();
        @(negedge clk);
        rd_addr1 = 3'd2; rd_addr2 = 3'd3;
        #1 check_all("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic writes, then read back on both ports.
        step(1, 3'd2, 8'hA5, 3'd2, 3'd3, 0, 3'd0, 0, "wr_r2");
        step(1, 3'd3, 8'h3C, 3'd2, 3'd3, 0, 3'd0, 0, "wr_r3");
        step(0, 3'd0, 8'h00, 3'd2, 3'd3, 0, 3'd0, 0, "rd_23");
        step(0, 3'd0, 8'h00, 3'd3, 3'd3, 0, 3'd0, 0, "rd_same");

        // Scoreboard: set, clear by writeback, and set winning over a same-cycle write.
        step(0, 3'd0, 8'h00, 3'd1, 3'd2, 1, 3'd1, 0, "pend_r1");
        step(1, 3'd1, 8'h77, 3'd1, 3'd2, 0, 3'd0, 0, "wr_r1");
        step(1, 3'd1, 8'h12, 3'd1, 3'd4, 1, 3'd1, 0, "pend_wr_r1");
        step(0, 3'd0, 8'h00, 3'd1, 3'd4, 0, 3'd0, 0, "pend_wins");

        // Hardwired zero and out-of-range address on the 5-entry instance.
        step(1, 3'd0, 8'h55, 3'd0, 3'd6, 1, 3'd0, 0, "zr_wr");
        step(1, 3'd6, 8'hEE, 3'd0, 3'd6, 1, 3'd7, 0, "oor_wr");
        step(0, 3'd0, 8'h00, 3'd0, 3'd6, 0, 3'd0, 0, "zr_oor_rd");

        // Fill everything, then clear while hammering r0 with writes.
        for (int k = 0; k < 8; k++) step(1, 3'(k), 8'(8'h10 + k * 8'h11), 3'(k), 3'(k), 0, 3'd0, 0, "fill");
        step(0, 3'd0, 8'h00, 3'd0, 3'd4, 1, 3'd3, 1, "clr_go");
        for (int k = 0; k < 7; k++) step(1, 3'd0, 8'hFF, 3'(k), 3'(k + 1), 1, 3'd2, 0, "clr_busy");
        step(0, 3'd0, 8'h00, 3'd0, 3'd1, 0, 3'd0, 0, "clr_done");

        // Accept a write issued in the same cycle as clr_req, then abort the clear with reset.
        step(1, 3'd3, 8'h5A, 3'd3, 3'd2, 0, 3'd0, 1, "clr_wr_same");
        step(0, 3'd0, 8'h00, 3'd3, 3'd2, 0, 3'd0, 0, "clr_mid1");
        step(0, 3'd0, 8'h00, 3'd3, 3'd4, 0, 3'd0, 0, "clr_mid2");
        reset = 1'b1;
        #1 model_reset();
        check_all("rst_mid");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 3'd1, 8'h42, 3'd1, 3'd3, 0, 3'd0, 0, "post_rst_wr");
        step(0, 3'd0, 8'h00, 3'd1, 3'd3, 0, 3'd0, 0, "post_rst_rd");

        // Same-cycle write and read of r2 (forwarding depends on build).
        step(1, 3'd2, 8'h9E, 3'd2, 3'd1, 0, 3'd0, 0, "bypass");
        step(0, 3'd0, 8'h00, 3'd2, 3'd1, 0, 3'd0, 0, "bypass_after");

        // Randomised traffic with occasional clears.
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 19) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
